// File: rtl/cve2_prefetch_buffer_nreq.sv
// Instruction prefetch buffer: up to NUM_REQS bus requests in flight feeding a FIFO_DEPTH-word FIFO.
// Define CVE2_PREFETCH_ERR_STOP_EN to stop issuing new fetches after an erroneous word until the next branch.
module cve2_prefetch_buffer_nreq #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  input  logic                          branch_i,
  input  logic [31:0]                   addr_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [31:0]                   rdata_o,
  output logic [31:0]                   addr_o,
  output logic                          err_o,
  output logic                          instr_req_o,
  input  logic                          instr_gnt_i,
  output logic [31:0]                   instr_addr_o,
  input  logic [31:0]                   instr_rdata_i,
  input  logic                          instr_err_i,
  input  logic                          instr_rvalid_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQS+1)-1:0] outstanding_o
);

  localparam int unsigned OW = $clog2(NUM_REQS + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SW = 6;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fifo_entry_t;

  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [OW-1:0] live_out;
  logic          held_q, held_d;
  logic          held_discard_q, held_discard_d;
  logic [31:0]   held_addr_q, held_addr_d;
  logic [31:0]   next_addr_q, next_addr_d;
  logic [31:0]   resp_addr_q, resp_addr_d;
  logic [31:0]   branch_addr, issue_addr;

  fifo_entry_t   fifo_mem [FIFO_DEPTH];
  fifo_entry_t   head, push_entry;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;

  logic grant, rv_live, rv_drop, push, pop;
  logic credit_ok, fetch_en, start;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];
  assign branch_addr     = {addr_i[31:2], 2'b00};
  assign issue_addr      = branch_i ? branch_addr : next_addr_q;

  assign grant   = held_q & instr_gnt_i;
  // Responses arriving with nothing outstanding belong to requests forgotten by reset.
  assign rv_live = instr_rvalid_i & (outstanding_q != '0);
  assign rv_drop = rv_live & (branch_i | (discard_q != '0));
  assign push    = rv_live & ~rv_drop;
  assign pop     = valid_o & ready_i;

  // Credit counts buffered words plus responses still destined for the FIFO.
  assign live_out  = outstanding_q - discard_q;
  assign credit_ok = branch_i | ((SW'(fifo_count_q) + SW'(live_out)) < SW'(FIFO_DEPTH));

`ifdef CVE2_PREFETCH_ERR_STOP_EN
  logic err_stop_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                    err_stop_q <= 1'b0;
    else if (branch_i)            err_stop_q <= 1'b0;
    else if (push && instr_err_i) err_stop_q <= 1'b1;
  end

  assign fetch_en = ~err_stop_q | branch_i;
`else
  assign fetch_en = 1'b1;
`endif

  assign start = req_i & ~held_q & (outstanding_q < OW'(NUM_REQS)) & credit_ok & fetch_en;

  assign outstanding_d = outstanding_q + OW'(grant) - OW'(rv_live);

  always_comb begin
    discard_d = discard_q;
    if (rv_live && (discard_q != '0)) discard_d = discard_d - OW'(1);
    if (grant && held_discard_q)      discard_d = discard_d + OW'(1);
    // Everything in flight after this cycle's grant/rvalid belongs to the old stream.
    if (branch_i)                     discard_d = outstanding_d;
  end

  always_comb begin
    held_d         = held_q & ~instr_gnt_i;
    held_addr_d    = held_addr_q;
    held_discard_d = held_discard_q;
    next_addr_d    = next_addr_q;
    if (branch_i) begin
      next_addr_d = branch_addr;
      if (held_q && !instr_gnt_i) held_discard_d = 1'b1;
    end
    if (start) begin
      held_d         = 1'b1;
      held_addr_d    = issue_addr;
      held_discard_d = 1'b0;
      next_addr_d    = issue_addr + 32'd4;
    end
  end

  always_comb begin
    resp_addr_d = resp_addr_q;
    if (branch_i)  resp_addr_d = branch_addr;
    else if (push) resp_addr_d = resp_addr_q + 32'd4;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q  <= '0;
      discard_q      <= '0;
      held_q         <= 1'b0;
      held_discard_q <= 1'b0;
      held_addr_q    <= '0;
      next_addr_q    <= '0;
      resp_addr_q    <= '0;
    end else begin
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
      held_q         <= held_d;
      held_discard_q <= held_discard_d;
      held_addr_q    <= held_addr_d;
      next_addr_q    <= next_addr_d;
      resp_addr_q    <= resp_addr_d;
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (branch_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  assign push_entry = '{rdata: instr_rdata_i, addr: resp_addr_q, err: instr_err_i};

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign head          = fifo_mem[rd_ptr_q];
  assign valid_o       = (fifo_count_q != '0);
  assign rdata_o       = head.rdata;
  assign addr_o        = head.addr;
  assign err_o         = valid_o & head.err;

  assign instr_req_o   = held_q;
  assign instr_addr_o  = held_addr_q;
  assign busy_o        = (outstanding_q != '0) | held_q;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_cve2_prefetch_buffer_nreq.sv
// Bench for cve2_prefetch_buffer_nreq: directed scenarios plus a random phase, checked against a
// bus/stream model (grant addresses and popped words must follow the last branch target sequentially).
module tb_cve2_prefetch_buffer_nreq;
  localparam int NUM_REQS   = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int OW         = $clog2(NUM_REQS + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, req_i, branch_i, ready_i;
  logic [31:0]   addr_i;
  logic          valid_o, err_o;
  logic [31:0]   rdata_o, addr_o;
  logic          instr_req_o, instr_gnt_i, instr_err_i, instr_rvalid_i;
  logic [31:0]   instr_addr_o, instr_rdata_i;
  logic          busy_o;
  logic [OW-1:0] outstanding_o;

  cve2_prefetch_buffer_nreq #(.NUM_REQS(NUM_REQS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .instr_rvalid_i(instr_rvalid_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o)
  );

  int          total = 0, bad = 0;
  int          gnt_pct = 100, rv_pct = 100;
  bit          rnd_err = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] pend[$];
  logic [31:0] glog[$];
  logic [31:0] plog[$];
  logic [31:0] egaddr = '0, exp_addr = '0, skip_addr = '0, prev_haddr = '0;
  bit          skip = 1'b0, prev_hold = 1'b0, prev_branch = 1'b0;
  logic [31:0] max_out = '0;
  int          err_pops = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return (a == err_addr) || (rnd_err && (a[6:2] == 5'd19));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] q[$], input int i, input logic [31:0] e);
    if (i < q.size()) check(tag, q[i], e);
    else check({tag, "_count"}, 32'(q.size()), 32'(i + 1));
  endtask

  // One clock: drive bus responses, check the current outputs, update the model, advance.
  task automatic tick();
    logic g, rv;
    g  = ($urandom_range(99) < gnt_pct);
    rv = (pend.size() != 0) && ($urandom_range(99) < rv_pct);
    instr_gnt_i    = g;
    instr_rvalid_i = rv;
    if (rv) begin
      instr_rdata_i = mem(pend[0]);
      instr_err_i   = errf(pend[0]);
    end else begin
      instr_rdata_i = $urandom;
      instr_err_i   = 1'($urandom_range(1));
    end
    check("outstanding", 32'(outstanding_o), 32'(pend.size()));
    check("busy", 32'(busy_o), 32'((pend.size() != 0) || instr_req_o));
    if (prev_hold) begin
      check("hold_req", 32'(instr_req_o), 32'd1);
      check("hold_addr", instr_addr_o, prev_haddr);
    end
    if (prev_branch) check("valid_after_branch", 32'(valid_o), 32'd0);
    if (instr_req_o) check("addr_align", 32'(instr_addr_o[1:0]), 32'd0);
    if (32'(outstanding_o) > max_out) max_out = 32'(outstanding_o);
    if (rv) void'(pend.pop_front());
    if (instr_req_o && g) begin
      check("grant_addr", instr_addr_o, skip ? skip_addr : egaddr);
      if (skip) skip = 1'b0;
      else egaddr += 32'd4;
      pend.push_back(instr_addr_o);
      glog.push_back(instr_addr_o);
    end
    if (valid_o && ready_i && !branch_i) begin
      check("pop_addr", addr_o, exp_addr);
      check("pop_data", rdata_o, mem(exp_addr));
      check("pop_err", 32'(err_o), 32'(errf(exp_addr)));
      if (err_o) err_pops++;
      plog.push_back(addr_o);
      exp_addr += 32'd4;
    end
    if (branch_i) begin
      if (instr_req_o && !g && !skip) begin
        skip      = 1'b1;
        skip_addr = egaddr;
      end
      egaddr   = {addr_i[31:2], 2'b00};
      exp_addr = egaddr;
    end
    prev_hold   = instr_req_o && !g;
    prev_haddr  = instr_addr_o;
    prev_branch = branch_i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic br(input logic [31:0] a);
    branch_i = 1'b1;
    addr_i   = a;
    tick();
    branch_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    pend.delete();
    egaddr = '0; exp_addr = '0; skip = 1'b0; prev_hold = 1'b0; prev_branch = 1'b0;
    check("rst_req", 32'(instr_req_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
  endtask

  task automatic drain();
    req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b1; gnt_pct = 100; rv_pct = 100;
    repeat (10) tick();
  endtask

  initial begin
    int   ep0;
    bit   has10c;
    rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    @(negedge clk);
    do_reset();

    // Straight-line fetch from 0x100
    req_i = 1'b1; ready_i = 1'b1; gnt_pct = 100; rv_pct = 100;
    glog.delete(); plog.delete(); max_out = '0;
    br(32'h100);
    repeat (14) tick();
    for (int i = 0; i < 4; i++) chk_q("seq_gnt", glog, i, 32'h100 + 32'(4 * i));
    for (int i = 0; i < 3; i++) chk_q("seq_pop", plog, i, 32'h100 + 32'(4 * i));
    check("max_outstanding_ok", 32'(max_out <= NUM_REQS), 32'd1);

    // Core stalls: credit limits grants to the FIFO depth
    drain();
    req_i = 1'b1; ready_i = 1'b0; glog.delete(); plog.delete();
    br(32'h400);
    repeat (12) tick();
    check("stall_grants", 32'(glog.size()), 32'(FIFO_DEPTH));
    check("stall_req_low", 32'(instr_req_o), 32'd0);
    check("stall_valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    repeat (10) tick();
    chk_q("stall_pop0", plog, 0, 32'h400);
    chk_q("stall_pop1", plog, 1, 32'h404);
    chk_q("stall_pop2", plog, 2, 32'h408);

    // Branch with two requests in flight
    drain();
    req_i = 1'b1; ready_i = 1'b0; rv_pct = 0; plog.delete();
    br(32'h100);
    repeat (6) tick();
    check("two_outstanding", 32'(outstanding_o), 32'd2);
    br(32'h200);
    rv_pct = 100; ready_i = 1'b1;
    repeat (12) tick();
    chk_q("flush_first_pop", plog, 0, 32'h200);

    // Branch while a request is held ungranted
    drain();
    req_i = 1'b1; gnt_pct = 0; glog.delete(); plog.delete();
    br(32'h100);
    tick();
    check("held_req", 32'(instr_req_o), 32'd1);
    br(32'h300);
    repeat (2) tick();
    check("held_addr_kept", instr_addr_o, 32'h100);
    gnt_pct = 100;
    repeat (10) tick();
    chk_q("held_gnt0", glog, 0, 32'h100);
    chk_q("held_gnt1", glog, 1, 32'h300);
    chk_q("held_pop0", plog, 0, 32'h300);

    // Bus error on 0x104
    drain();
    err_addr = 32'h104; ep0 = err_pops;
    req_i = 1'b1; ready_i = 1'b1; glog.delete(); plog.delete();
    br(32'h100);
    repeat (20) tick();
    chk_q("err_word_addr", plog, 1, 32'h104);
    check("err_pops", 32'(err_pops - ep0), 32'd1);
    has10c = 1'b0;
    foreach (glog[i]) if (glog[i] == 32'h10C) has10c = 1'b1;
`ifdef CVE2_PREFETCH_ERR_STOP_EN
    check("err_stop_no_10c", 32'(has10c), 32'd0);
`else
    check("err_continue_10c", 32'(has10c), 32'd1);
`endif
    drain();
    err_addr = 32'hFFFF_FFFF;

    // Address wrap, unaligned target
    req_i = 1'b1; glog.delete(); plog.delete();
    br(32'hFFFF_FFFB);
    repeat (12) tick();
    chk_q("wrap_gnt0", glog, 0, 32'hFFFF_FFF8);
    chk_q("wrap_gnt1", glog, 1, 32'hFFFF_FFFC);
    chk_q("wrap_gnt2", glog, 2, 32'h0000_0000);
    chk_q("wrap_pop2", plog, 2, 32'h0000_0000);

    // Reset with requests in flight; stale rvalids must be ignored
    drain();
    req_i = 1'b1; ready_i = 1'b0; rv_pct = 0;
    br(32'h500);
    repeat (5) tick();
    check("pre_reset_out", 32'(outstanding_o), 32'd2);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_i = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("stale_out", 32'(outstanding_o), 32'd0);
      check("stale_valid", 32'(valid_o), 32'd0);
    end
    instr_rvalid_i = 1'b0;

    // Random traffic
    rnd_err = 1'b1; gnt_pct = 60; rv_pct = 50; max_out = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      req_i   = ($urandom_range(99) < 90);
      ready_i = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) br($urandom);
      else tick();
    end
    check("rand_max_outstanding_ok", 32'(max_out <= NUM_REQS), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
